axis_frame_guard: RTL and testbench

Downstream stage for the AXI-stream FIFO: consumes its `m_axis` output and enforces per-frame length limits before frames leave the subsystem. Frames longer than `MAX_BEATS` are truncated, and the rest of the frame is discarded. Frames shorter than `MIN_BEATS` are passed through but marked in error. A registered two-entry skid output keeps full throughput, and per-frame status pulses and a frame counter are exported.

---
 rtl/axis_frame_guard.sv | 178 +++++++++++++++++
 tb/tb_axis_frame_guard.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_guard.sv
// Length guard for an AXI-stream: truncates frames longer than MAX_BEATS and flags runts below MIN_BEATS.
// Latency: one cycle from input handshake to m_axis_tvalid when the output is not stalled.
// Backpressure: two-entry skid output; s_axis_tready is registered and drops only while the skid entry is full.
`timescale 1ns/1ps
module axis_frame_guard #(
   parameter int DATA_W    = 8,
   parameter int KEEP_W    = (DATA_W + 7) / 8,
   parameter int ID_W      = 8,
   parameter int DST_W     = 8,
   parameter int USR_W     = 1,
   parameter int MAX_BEATS = 64,
   parameter int MIN_BEATS = 1,
   parameter int CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_srst_n,
   input  logic [DATA_W-1:0] i_s_axis_tdata,
   input  logic [KEEP_W-1:0] i_s_axis_tkeep,
   input  logic              i_s_axis_tlast,
   input  logic [ID_W-1:0]   i_s_axis_tid,
   input  logic [DST_W-1:0]  i_s_axis_tdest,
   input  logic [USR_W-1:0]  i_s_axis_tuser,
   input  logic              i_s_axis_tvalid,
   output logic              o_s_axis_tready,
   output logic [DATA_W-1:0] o_m_axis_tdata,
   output logic [KEEP_W-1:0] o_m_axis_tkeep,
   output logic              o_m_axis_tlast,
   output logic [ID_W-1:0]   o_m_axis_tid,
   output logic [DST_W-1:0]  o_m_axis_tdest,
   output logic [USR_W-1:0]  o_m_axis_tuser,
   output logic              o_m_axis_tvalid,
   input  logic              i_m_axis_tready,
   output logic              o_stat_good_frame,
   output logic              o_stat_runt_frame,
   output logic              o_stat_trunc_frame,
   output logic [CNT_W-1:0]  o_stat_frame_cnt
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam int BW = DATA_W + KEEP_W + 1 + ID_W + DST_W + USR_W;
   // count value held while the last permitted beat is being accepted
   localparam logic [CW-1:0] LP_CNT_TRUNC = CW'(MAX_BEATS - 1);
   localparam logic [CW-1:0] LP_CNT_MAX   = CW'(MAX_BEATS);
   localparam logic [CW:0]   LP_MIN       = (CW + 1)'(MIN_BEATS);

   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;
   logic [CW:0]      w_final_len;
   logic             w_acc, w_push, w_last_out;
   logic [USR_W-1:0] w_user_out;
   logic             w_good, w_runt, w_trunc;
   logic [BW-1:0]    w_beat, r_main, r_skid;
   logic             r_main_vld, r_skid_vld, r_rdy;
   logic             w_pop, w_main_load, w_skid_nxt;
   logic             r_good, r_runt, r_trunc;
   logic [CNT_W-1:0] r_frame_cnt;

   assign w_acc       = i_s_axis_tvalid & r_rdy;
   // length of the frame if the beat being accepted now were its last
   assign w_final_len = {1'b0, r_beat_cnt} + 1'b1;

   // Frame state and beat counter register
   always_ff @(posedge i_clk or negedge i_srst_n) begin
      if (!i_srst_n) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // Next state, forwarded beat fields and per-frame classification
   always_comb begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
      w_push         = 1'b0;
      w_last_out     = i_s_axis_tlast;
      w_user_out     = i_s_axis_tuser;
      w_good         = 1'b0;
      w_runt         = 1'b0;
      w_trunc        = 1'b0;
      case (r_state)
         ST_IDLE, ST_PASS: begin
            if (w_acc) begin
               w_push = 1'b1;
               if (i_s_axis_tlast) begin
                  w_state_nxt    = ST_IDLE;
                  w_beat_cnt_nxt = '0;
                  if (w_final_len < LP_MIN) begin
                     w_runt        = 1'b1;
                     w_user_out[0] = 1'b1;
                  end else begin
                     w_good = 1'b1;
                  end
               end else if (r_beat_cnt == LP_CNT_TRUNC) begin
                  // last permitted beat without tlast: close the frame here, drop the tail
                  w_state_nxt    = ST_DROP;
                  w_beat_cnt_nxt = LP_CNT_MAX;
                  w_last_out     = 1'b1;
                  w_user_out[0]  = 1'b1;
                  w_trunc        = 1'b1;
               end else begin
                  w_state_nxt    = ST_PASS;
                  w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               end
            end
         end
         ST_DROP: begin
            if (w_acc && i_s_axis_tlast) begin
               w_state_nxt    = ST_IDLE;
               w_beat_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_beat_cnt_nxt = '0;
         end
      endcase
   end

   assign w_beat      = {i_s_axis_tdata, i_s_axis_tkeep, w_last_out, i_s_axis_tid, i_s_axis_tdest, w_user_out};
   assign w_pop       = r_main_vld & i_m_axis_tready;
   assign w_main_load = ~r_main_vld | w_pop;
   // skid keeps a beat only when main cannot take one this cycle
   assign w_skid_nxt  = w_main_load ? (r_skid_vld & w_push) : (r_skid_vld | w_push);

   // Two-entry output buffer: main feeds m_axis, skid absorbs the beat in flight during a stall
   always_ff @(posedge i_clk or negedge i_srst_n) begin
      if (!i_srst_n) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
         r_rdy      <= 1'b0;
         r_main     <= '0;
         r_skid     <= '0;
      end else begin
         if (w_main_load) begin
            r_main_vld <= r_skid_vld | w_push;
            r_main     <= r_skid_vld ? r_skid : w_beat;
         end
         // harmless when the beat goes straight to main: skid stays invalid
         if (w_push) begin
            r_skid <= w_beat;
         end
         r_skid_vld <= w_skid_nxt;
         r_rdy      <= ~w_skid_nxt;
      end
   end

   // Registered status pulses and emitted-frame counter
   always_ff @(posedge i_clk or negedge i_srst_n) begin
      if (!i_srst_n) begin
         r_good      <= 1'b0;
         r_runt      <= 1'b0;
         r_trunc     <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_good  <= w_good;
         r_runt  <= w_runt;
         r_trunc <= w_trunc;
         if (w_push && w_last_out) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign {o_m_axis_tdata, o_m_axis_tkeep, o_m_axis_tlast,
           o_m_axis_tid, o_m_axis_tdest, o_m_axis_tuser} = r_main;
   assign o_m_axis_tvalid    = r_main_vld;
   assign o_s_axis_tready    = r_rdy;
   assign o_stat_good_frame  = r_good;
   assign o_stat_runt_frame  = r_runt;
   assign o_stat_trunc_frame = r_trunc;
   assign o_stat_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_axis_frame_guard.sv
// Bench for axis_frame_guard: frame table, hand-timed corner sequences and random traffic vs a frame-level model.
// Latency: checks the one-cycle input-to-output path and the registered tready after reset.
// Backpressure: drives m_axis_tready always-on, in a 1,0,0,1 pattern, or randomly.
`timescale 1ns/1ps
module tb_axis_frame_guard;
   localparam int MAXB = 8;
   localparam int MINB = 3;
   localparam int CNTW = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       last;
      logic [3:0] id;
      logic [3:0] dest;
      logic [1:0] user;
   } beat_t;

   typedef struct {
      int         len;
      logic [7:0] base;
      logic [1:0] user;
      int         exp_out;
      bit         exp_err;
      bit         exp_good;
      bit         exp_runt;
      bit         exp_trunc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] s_tdata = '0;
   logic       s_tkeep = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
   logic [3:0] s_tid = '0, s_tdest = '0;
   logic [1:0] s_tuser = '0;
   logic       s_tready;
   logic [7:0] m_tdata;
   logic       m_tkeep, m_tlast, m_tvalid;
   logic       m_tready = 1'b1;
   logic [3:0] m_tid, m_tdest;
   logic [1:0] m_tuser;
   logic       stat_good, stat_runt, stat_trunc;
   logic [CNTW-1:0] frame_cnt;
   beat_t      m_beat;

   int vectors = 0, miscompares = 0;
   beat_t got_q[$], exp_q[$], cur_frame[$];
   int got_good = 0, got_runt = 0, got_trunc = 0;
   int exp_good = 0, exp_runt = 0, exp_trunc = 0, exp_frames = 0;
   int tr_mode = 0, tr_idx = 0, cyc = 0;
   bit bp_chk = 1'b0, prev_stall = 1'b0;
   int in_acc = 0, out_acc = 0, bp_low = 0;
   beat_t prev_beat;
   vec_t tbl[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   axis_frame_guard #(
      .DATA_W(8), .KEEP_W(1), .ID_W(4), .DST_W(4), .USR_W(2),
      .MAX_BEATS(MAXB), .MIN_BEATS(MINB), .CNT_W(CNTW)
   ) dut (
      .i_clk(clk), .i_srst_n(rst_n),
      .i_s_axis_tdata(s_tdata), .i_s_axis_tkeep(s_tkeep), .i_s_axis_tlast(s_tlast),
      .i_s_axis_tid(s_tid), .i_s_axis_tdest(s_tdest), .i_s_axis_tuser(s_tuser),
      .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready),
      .o_m_axis_tdata(m_tdata), .o_m_axis_tkeep(m_tkeep), .o_m_axis_tlast(m_tlast),
      .o_m_axis_tid(m_tid), .o_m_axis_tdest(m_tdest), .o_m_axis_tuser(m_tuser),
      .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
      .o_stat_good_frame(stat_good), .o_stat_runt_frame(stat_runt),
      .o_stat_trunc_frame(stat_trunc), .o_stat_frame_cnt(frame_cnt)
   );

   assign m_beat = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   // Output sink: hold-stability, collected beats, status pulses, buffer occupancy vs tready
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("hold_stable", 32'({m_tvalid, m_beat}), 32'({1'b1, prev_beat}));
         if (m_tvalid && m_tready) got_q.push_back(m_beat);
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = m_beat;
         if (stat_good)  got_good++;
         if (stat_runt)  got_runt++;
         if (stat_trunc) got_trunc++;
         if (bp_chk) begin
            check("skid_tready", 32'(s_tready), 32'((in_acc - out_acc) < 2));
            if (!s_tready) bp_low++;
            if (s_tvalid && s_tready) in_acc++;
            if (m_tvalid && m_tready) out_acc++;
         end
      end
   end

   // Output ready generator
   initial begin
      forever begin
         @(posedge clk); #1;
         case (tr_mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 3) != 0);
            default: begin
               m_tready = ((tr_idx % 4) == 0) || ((tr_idx % 4) == 3);
               tr_idx++;
            end
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void build_frame(input int len, input logic [7:0] base, input logic [3:0] id,
                                       input logic [3:0] dest, input logic [1:0] user, input bit rnd);
      beat_t b;
      cur_frame.delete();
      for (int i = 0; i < len; i++) begin
         b.data = rnd ? 8'($urandom) : base + 8'(i);
         b.keep = 1'b1;
         b.last = (i == len - 1);
         b.id   = id;
         b.dest = dest;
         b.user = user;
         cur_frame.push_back(b);
      end
   endfunction

   // Frame-level reference: keep at most MAXB beats, close and flag on truncation or runt
   function automatic void model_frame();
      int n, k;
      beat_t b;
      n = cur_frame.size();
      k = (n > MAXB) ? MAXB : n;
      for (int i = 0; i < k; i++) begin
         b = cur_frame[i];
         if (i == k - 1) begin
            b.last = 1'b1;
            if (n > MAXB || n < MINB) b.user[0] = 1'b1;
         end
         exp_q.push_back(b);
      end
      if (n > MAXB)      exp_trunc++;
      else if (n < MINB) exp_runt++;
      else               exp_good++;
      exp_frames++;
   endfunction

   task automatic push_beat(input beat_t b);
      int waitc;
      bit acc;
      waitc = 0;
      acc = 1'b0;
      s_tvalid = 1'b1;
      {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = b;
      while (!acc) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk); #1;
         waitc++;
         if (!acc && waitc >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: beat not accepted after %0d cycles", waitc);
            break;
         end
      end
   endtask

   task automatic send_frame(input int gap_pct);
      for (int i = 0; i < cur_frame.size(); i++) begin
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         push_beat(cur_frame[i]);
      end
      s_tvalid = 1'b0;
      model_frame();
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((got_q.size() < exp_q.size() || m_tvalid) && c < 2000) begin
         @(posedge clk); #1;
         c++;
      end
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic compare_model(input string tag);
      int n;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check({tag, "_good"},  32'(got_good),  32'(exp_good));
      check({tag, "_runt"},  32'(got_runt),  32'(exp_runt));
      check({tag, "_trunc"}, 32'(got_trunc), 32'(exp_trunc));
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames % (1 << CNTW)));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_tvalid = 1'b0;
      bp_chk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      got_good = 0; got_runt = 0; got_trunc = 0;
      exp_good = 0; exp_runt = 0; exp_trunc = 0; exp_frames = 0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int pre, g0, r0, t0, n, t_start;
      beat_t eb;

      //          len  base   user   out err good runt trunc
      tbl[0] = '{ 4, 8'h10, 2'b00, 4, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{12, 8'h00, 2'b00, 8, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{ 3, 8'h20, 2'b00, 3, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{ 1, 8'hAA, 2'b00, 1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{ 2, 8'h30, 2'b10, 2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{ 8, 8'h40, 2'b00, 8, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{ 9, 8'h50, 2'b10, 8, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{ 3, 8'h60, 2'b01, 3, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset with a valid beat presented
      rst_n = 1'b0;
      s_tvalid = 1'b1;
      s_tdata = 8'h77;
      s_tlast = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_stats", 32'({stat_good, stat_runt, stat_trunc}), 32'd0);
      #1;
      s_tvalid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rst_rdy_before_edge", 32'(s_tready), 32'd0);
      @(negedge clk);
      check("rst_rdy_after_edge", 32'(s_tready), 32'd1);

      // One-cycle latency on a single-beat (runt) frame
      build_frame(1, 8'h5A, 4'h1, 4'h2, 2'b00, 1'b0);
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = cur_frame[0];
      @(negedge clk);
      check("lat_pre_vld", 32'(m_tvalid), 32'd0);
      check("lat_rdy", 32'(s_tready), 32'd1);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      @(negedge clk);
      check("lat_vld", 32'(m_tvalid), 32'd1);
      check("lat_data", 32'(m_tdata), 32'h5A);
      check("lat_last_err", 32'({m_tlast, m_tuser}), 32'b101);
      check("lat_runt", 32'(stat_runt), 32'd1);
      check("lat_cnt", 32'(frame_cnt), 32'd1);
      @(negedge clk);
      check("lat_pulse_end", 32'(stat_runt), 32'd0);
      model_frame();
      drain();
      compare_model("lat");

      // Frame table
      for (int k = 0; k < 8; k++) begin
         pre = got_q.size();
         g0 = got_good; r0 = got_runt; t0 = got_trunc;
         build_frame(tbl[k].len, tbl[k].base, 4'(k), 4'(15 - k), tbl[k].user, 1'b0);
         send_frame(0);
         drain();
         n = got_q.size() - pre;
         check($sformatf("tbl%0d_nbeats", k), 32'(n), 32'(tbl[k].exp_out));
         for (int i = 0; i < n; i++) begin
            eb.data = tbl[k].base + 8'(i);
            eb.keep = 1'b1;
            eb.last = (i == n - 1);
            eb.id   = 4'(k);
            eb.dest = 4'(15 - k);
            eb.user = (i == n - 1) ? {tbl[k].user[1], tbl[k].exp_err} : tbl[k].user;
            check($sformatf("tbl%0d_beat%0d", k, i), 32'(got_q[pre + i]), 32'(eb));
         end
         check($sformatf("tbl%0d_good", k),  32'(got_good - g0),  32'(tbl[k].exp_good));
         check($sformatf("tbl%0d_runt", k),  32'(got_runt - r0),  32'(tbl[k].exp_runt));
         check($sformatf("tbl%0d_trunc", k), 32'(got_trunc - t0), 32'(tbl[k].exp_trunc));
      end
      compare_model("tbl");

      // Backpressure: back-to-back 5-beat frames under a 1,0,0,1 ready pattern
      tr_idx = 0;
      in_acc = 0; out_acc = 0; bp_low = 0;
      bp_chk = 1'b1;
      tr_mode = 2;
      for (int f = 0; f < 3; f++) begin
         build_frame(5, 8'(8'hC0 + 8'(f * 16)), 4'(f), 4'h3, 2'b00, 1'b0);
         send_frame(0);
      end
      drain();
      bp_chk = 1'b0;
      tr_mode = 0;
      check("bp_tready_low_seen", 32'(bp_low > 0), 32'd1);
      compare_model("bp");
      @(posedge clk); #1;
      build_frame(5, 8'hE0, 4'h4, 4'h4, 2'b00, 1'b0);
      t_start = cyc;
      send_frame(0);
      check("full_rate_cycles", 32'(cyc - t_start), 32'd5);
      drain();
      compare_model("rate");

      // Random traffic with random output stalls
      tr_mode = 1;
      for (int f = 0; f < 40; f++) begin
         build_frame(int'($urandom_range(1, 12)), 8'h00, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
         send_frame(20);
      end
      drain();
      tr_mode = 0;
      compare_model("rnd");

      // Reset in the middle of a frame: next beat starts a fresh frame
      build_frame(12, 8'h80, 4'h5, 4'h6, 2'b00, 1'b0);
      for (int i = 0; i < 6; i++) push_beat(cur_frame[i]);
      s_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      build_frame(4, 8'h90, 4'h7, 4'h8, 2'b00, 1'b0);
      send_frame(0);
      drain();
      compare_model("midrst");

      // Frame counter wrap at 2^CNTW
      do_reset();
      for (int f = 0; f < 17; f++) begin
         build_frame(1, 8'(f), 4'h9, 4'hA, 2'b00, 1'b0);
         send_frame(0);
      end
      drain();
      check("wrap_cnt", 32'(frame_cnt), 32'd1);
      compare_model("wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
